// File: rtl/iq_fifo_reader.sv
// Read-side controller for the 4-deep I/Q sample FIFO: pulls pairs into a 2-entry
// skid buffer, presents them over valid/ready, tags frame edges and flags underrun.
module iq_fifo_reader #(
   parameter int DW        = 24,
   parameter int FRAME_LEN = 64,
   parameter int PW        = $clog2(FRAME_LEN)
) (
   input  logic          clk,
   input  logic          reset,
   input  logic          Enable,
   input  logic          ClearErr,
   input  logic          FifoEmpty,
   input  logic [DW-1:0] FifoI,
   input  logic [DW-1:0] FifoQ,
   output logic          PullOut,
   output logic          OutValid,
   input  logic          OutReady,
   output logic [DW-1:0] OutI,
   output logic [DW-1:0] OutQ,
   output logic          OutFirst,
   output logic          OutLast,
   output logic          Busy,
   output logic          Underrun
);

   typedef enum logic [1:0] {IDLE, RUN, DRAIN} state_t;

   state_t        state_q, state_d;
   logic [1:0]    occ_q, occ_d;
   logic [PW-1:0] pos_q, pos_d;
   logic [DW-1:0] head_i_q, head_i_d, head_q_q, head_q_d;
   logic [DW-1:0] tail_i_q, tail_i_d, tail_q_q, tail_q_d;
   logic          underrun_q, underrun_d;
   logic          first_q, first_d;
   logic          last_q, last_d;
   logic          pop;
   logic [1:0]    wr_idx;

   localparam logic [PW-1:0] POS_LAST = PW'(FRAME_LEN - 1);

   assign pop      = OutValid & OutReady;
   // The FIFO read pointer is unguarded, so FifoEmpty must gate the strobe.
   assign PullOut  = (state_q == RUN) & ~FifoEmpty & ((occ_q < 2'd2) | pop);
   assign OutValid = (occ_q != 2'd0);
   assign OutI     = head_i_q;
   assign OutQ     = head_q_q;
   assign OutFirst = first_q;
   assign OutLast  = last_q;
   assign Busy     = (state_q != IDLE);
   assign Underrun = underrun_q;

   // Slot the incoming sample lands in, after any pop has shifted the tail forward.
   assign wr_idx = occ_q - {1'b0, pop};

   always_comb begin
      head_i_d = head_i_q;
      head_q_d = head_q_q;
      tail_i_d = tail_i_q;
      tail_q_d = tail_q_q;
      if (pop) begin
         head_i_d = tail_i_q;
         head_q_d = tail_q_q;
      end
      if (PullOut) begin
         if (wr_idx == 2'd0) begin
            head_i_d = FifoI;
            head_q_d = FifoQ;
         end else begin
            tail_i_d = FifoI;
            tail_q_d = FifoQ;
         end
      end

      occ_d = occ_q + {1'b0, PullOut} - {1'b0, pop};

      pos_d = pos_q;
      if (pop) begin
         pos_d = (pos_q == POS_LAST) ? '0 : pos_q + PW'(1);
      end

      first_d = (occ_d != 2'd0) & (pos_d == '0);
      last_d  = (occ_d != 2'd0) & (pos_d == POS_LAST);

      // Set has priority over the clear request.
      underrun_d = ((state_q == RUN) & (pos_q != '0) & (occ_q == 2'd0) & FifoEmpty)
                 | (underrun_q & ~ClearErr);

      state_d = state_q;
      case (state_q)
         IDLE:    if (Enable) state_d = RUN;
         RUN:     if (!Enable) state_d = (occ_d != 2'd0) ? DRAIN : IDLE;
         DRAIN: begin
            if (Enable)              state_d = RUN;
            else if (occ_d == 2'd0)  state_d = IDLE;
         end
         default: state_d = IDLE;
      endcase
   end

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q    <= IDLE;
         occ_q      <= 2'd0;
         pos_q      <= '0;
         head_i_q   <= '0;
         head_q_q   <= '0;
         tail_i_q   <= '0;
         tail_q_q   <= '0;
         underrun_q <= 1'b0;
         first_q    <= 1'b0;
         last_q     <= 1'b0;
      end else begin
         state_q    <= state_d;
         occ_q      <= occ_d;
         pos_q      <= pos_d;
         head_i_q   <= head_i_d;
         head_q_q   <= head_q_d;
         tail_i_q   <= tail_i_d;
         tail_q_q   <= tail_q_d;
         underrun_q <= underrun_d;
         first_q    <= first_d;
         last_q     <= last_d;
      end
   end

endmodule

// File: tb/tb_iq_fifo_reader.sv
// Bench for iq_fifo_reader: queue-level reference model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_iq_fifo_reader;

   localparam int DW = 24;
   localparam int FL = 4;

   typedef struct packed {
      logic [DW-1:0] i;
      logic [DW-1:0] q;
   } samp_t;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic          Enable = 1'b0;
   logic          ClearErr = 1'b0;
   logic          FifoEmpty = 1'b1;
   logic [DW-1:0] FifoI = '0;
   logic [DW-1:0] FifoQ = '0;
   logic          PullOut;
   logic          OutValid;
   logic          OutReady = 1'b0;
   logic [DW-1:0] OutI;
   logic [DW-1:0] OutQ;
   logic          OutFirst;
   logic          OutLast;
   logic          Busy;
   logic          Underrun;

   int tests = 0;
   int fails = 0;

   samp_t src[$];   // contents of the upstream FIFO
   samp_t mq[$];    // model of samples held by the reader
   int    m_pos  = 0;
   int    m_mode = 0;   // 0 idle, 1 running, 2 draining
   logic  m_und  = 1'b0;

   iq_fifo_reader #(.DW(DW), .FRAME_LEN(FL)) dut (
      .clk(clk), .reset(rst_n), .Enable(Enable), .ClearErr(ClearErr),
      .FifoEmpty(FifoEmpty), .FifoI(FifoI), .FifoQ(FifoQ), .PullOut(PullOut),
      .OutValid(OutValid), .OutReady(OutReady), .OutI(OutI), .OutQ(OutQ),
      .OutFirst(OutFirst), .OutLast(OutLast), .Busy(Busy), .Underrun(Underrun)
   );

   always #5 clk = ~clk;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      tests++;
      if (act !== exp) begin
         fails++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic refresh_fifo();
      FifoEmpty = (src.size() == 0);
      if (src.size() != 0) begin
         FifoI = src[0].i;
         FifoQ = src[0].q;
      end
   endtask

   task automatic load(input logic [DW-1:0] i, input logic [DW-1:0] q);
      samp_t s;
      s.i = i;
      s.q = q;
      src.push_back(s);
      refresh_fifo();
   endtask

   task automatic tick();
      @(posedge clk);
      #2;
   endtask

   task automatic model_reset();
      mq.delete();
      m_pos  = 0;
      m_mode = 0;
      m_und  = 1'b0;
   endtask

   // Reference model and per-cycle compare.
   initial begin
      logic p_pop, p_pull, p_set, c_en, c_clr, c_empty;
      samp_t s;
      forever begin
         @(negedge clk);
         if (!rst_n) begin
            model_reset();
            continue;
         end
         c_en    = Enable;
         c_clr   = ClearErr;
         c_empty = (src.size() == 0);
         p_pop   = (mq.size() > 0) && OutReady;
         p_pull  = (m_mode == 1) && !c_empty && ((mq.size() < 2) || p_pop);
         p_set   = (m_mode == 1) && (m_pos != 0) && (mq.size() == 0) && c_empty;

         chk("m_valid", 32'(OutValid), 32'(mq.size() > 0));
         chk("m_pull", 32'(PullOut), 32'(p_pull));
         chk("m_busy", 32'(Busy), 32'(m_mode != 0));
         chk("m_underrun", 32'(Underrun), 32'(m_und));
         if (mq.size() > 0) begin
            chk("m_out_i", 32'(OutI), 32'(mq[0].i));
            chk("m_out_q", 32'(OutQ), 32'(mq[0].q));
            chk("m_first", 32'(OutFirst), 32'(m_pos == 0));
            chk("m_last", 32'(OutLast), 32'(m_pos == FL - 1));
         end else begin
            chk("m_first_idle", 32'(OutFirst), 32'd0);
            chk("m_last_idle", 32'(OutLast), 32'd0);
         end

         @(posedge clk);
         #1;
         if (!rst_n) begin
            model_reset();
            continue;
         end
         if (p_pop) begin
            void'(mq.pop_front());
            m_pos = (m_pos + 1) % FL;
         end
         if (p_pull) begin
            s = src.pop_front();
            mq.push_back(s);
         end
         m_und = p_set | (m_und & ~c_clr);
         case (m_mode)
            0: if (c_en) m_mode = 1;
            1: if (!c_en) m_mode = (mq.size() > 0) ? 2 : 0;
            default: begin
               if (c_en) m_mode = 1;
               else if (mq.size() == 0) m_mode = 0;
            end
         endcase
         refresh_fifo();
      end
   end

   task automatic do_reset();
      rst_n    = 1'b0;
      Enable   = 1'b0;
      OutReady = 1'b0;
      ClearErr = 1'b0;
      src.delete();
      refresh_fifo();
      tick();
      chk("rst_valid", 32'(OutValid), 32'd0);
      chk("rst_out_i", 32'(OutI), 32'd0);
      chk("rst_busy", 32'(Busy), 32'd0);
      chk("rst_underrun", 32'(Underrun), 32'd0);
      tick();
      rst_n = 1'b1;
   endtask

   initial begin
      int n;
      logic [15:0] firsts, lasts;

      // Idle with data available: nothing may be pulled.
      do_reset();
      for (int k = 0; k < 4; k++) load(DW'(k + 1), DW'(32'h100 + k));
      tick(); tick(); tick();
      chk("idle_pull", 32'(PullOut), 32'd0);
      chk("idle_busy", 32'(Busy), 32'd0);
      chk("idle_valid", 32'(OutValid), 32'd0);
      chk("idle_out_q", 32'(OutQ), 32'd0);
      chk("idle_first", 32'(OutFirst), 32'd0);

      // Streaming at full rate.
      OutReady = 1'b1;
      Enable   = 1'b1;
      tick();
      chk("run_pull", 32'(PullOut), 32'd1);
      tick();
      chk("run_i1", 32'(OutI), 32'd1);
      chk("run_q1", 32'(OutQ), 32'h100);
      chk("run_first1", 32'(OutFirst), 32'd1);
      tick();
      chk("run_i2", 32'(OutI), 32'd2);
      chk("run_first2", 32'(OutFirst), 32'd0);
      tick();
      chk("run_i3", 32'(OutI), 32'd3);
      tick();
      chk("run_i4", 32'(OutI), 32'd4);
      chk("run_last4", 32'(OutLast), 32'd1);
      chk("run_pull_empty", 32'(PullOut), 32'd0);
      tick();
      chk("run_drained", 32'(OutValid), 32'd0);
      Enable = 1'b0;
      tick();

      // Back-pressure: two pulls then hold.
      do_reset();
      for (int k = 0; k < 3; k++) load(DW'(32'h11 + k), DW'(32'h211 + k));
      Enable = 1'b1;
      tick();
      chk("bp_pull", 32'(PullOut), 32'd1);
      tick(); tick();
      chk("bp_valid", 32'(OutValid), 32'd1);
      chk("bp_head", 32'(OutI), 32'h11);
      chk("bp_full_nopull", 32'(PullOut), 32'd0);
      tick(); tick();
      chk("bp_hold", 32'(OutI), 32'h11);
      chk("bp_hold_first", 32'(OutFirst), 32'd1);
      OutReady = 1'b1;
      tick();
      chk("bp_out2", 32'(OutI), 32'h12);
      tick();
      chk("bp_out3", 32'(OutI), 32'h13);
      chk("bp_out3_q", 32'(OutQ), 32'h213);
      tick();
      chk("bp_done", 32'(OutValid), 32'd0);
      Enable = 1'b0;
      tick();

      // Frame tagging over 9 samples.
      do_reset();
      for (int k = 0; k < 9; k++) load(DW'(32'h31 + k), DW'(32'h331 + k));
      OutReady = 1'b1;
      Enable   = 1'b1;
      n = 0;
      firsts = '0;
      lasts  = '0;
      for (int c = 0; c < 14; c++) begin
         tick();
         if (OutValid && n < 16) begin
            if (OutFirst) firsts[n] = 1'b1;
            if (OutLast) lasts[n] = 1'b1;
            n++;
         end
      end
      chk("frm_count", 32'(n), 32'd9);
      chk("frm_firsts", 32'(firsts), 32'h0111);
      chk("frm_lasts", 32'(lasts), 32'h0088);
      Enable = 1'b0;
      tick();

      // Underrun set, set-beats-clear, then clear.
      do_reset();
      load(DW'(32'h41), DW'(32'h441));
      load(DW'(32'h42), DW'(32'h442));
      OutReady = 1'b1;
      Enable   = 1'b1;
      tick(); tick(); tick(); tick();
      chk("ur_before", 32'(Underrun), 32'd0);
      chk("ur_empty", 32'(OutValid), 32'd0);
      tick();
      chk("ur_set", 32'(Underrun), 32'd1);
      ClearErr = 1'b1;
      tick();
      chk("ur_set_wins", 32'(Underrun), 32'd1);
      ClearErr = 1'b0;
      Enable   = 1'b0;
      tick();
      chk("ur_sticky", 32'(Underrun), 32'd1);
      chk("ur_idle", 32'(Busy), 32'd0);
      ClearErr = 1'b1;
      tick();
      chk("ur_cleared", 32'(Underrun), 32'd0);
      ClearErr = 1'b0;
      tick();

      // Drain, then asynchronous reset while draining.
      do_reset();
      for (int k = 0; k < 3; k++) load(DW'(32'h51 + k), DW'(32'h551 + k));
      Enable = 1'b1;
      tick(); tick(); tick();
      chk("dr_head", 32'(OutI), 32'h51);
      chk("dr_full", 32'(PullOut), 32'd0);
      Enable = 1'b0;
      tick();
      chk("dr_busy", 32'(Busy), 32'd1);
      chk("dr_nopull", 32'(PullOut), 32'd0);
      OutReady = 1'b1;
      tick();
      chk("dr_busy1", 32'(Busy), 32'd1);
      chk("dr_next", 32'(OutI), 32'h52);
      chk("dr_nopull1", 32'(PullOut), 32'd0);
      tick();
      chk("dr_idle", 32'(Busy), 32'd0);
      chk("dr_empty", 32'(OutValid), 32'd0);
      OutReady = 1'b0;
      load(DW'(32'h54), DW'(32'h554));
      Enable = 1'b1;
      tick(); tick(); tick();
      Enable = 1'b0;
      tick();
      chk("dr2_busy", 32'(Busy), 32'd1);
      chk("dr2_valid", 32'(OutValid), 32'd1);
      #1;
      rst_n = 1'b0;
      #1;
      chk("arst_valid", 32'(OutValid), 32'd0);
      chk("arst_busy", 32'(Busy), 32'd0);
      chk("arst_out_i", 32'(OutI), 32'd0);
      tick();
      rst_n = 1'b1;
      tick(); tick();

      $display("[TB] %0d tests run, %0d failed", tests, fails);
      $finish;
   end

endmodule
